// File: rtl/sram_wmask_pkg.sv
// rtl/sram_wmask_pkg.sv - shared types and helpers for the 1RW write-mask SRAM model
package sram_wmask_pkg;

  localparam int READ_LATENCY_MAX = 4;

  typedef enum logic [1:0] {ACC_IDLE, ACC_RD, ACC_WR} acc_e;

  function automatic int num_wmasks(input int word, input int write);
    return word / write;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - read shift register of {valid, err, data} ending in the dout register
module sram_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  input  logic             corrupt,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld_q, vld_d, err_q, err_d;
  logic [WIDTH-1:0]   tail_data, dout_q, dout_d;

  // Intermediate data stages carry no reset; only valid/err decide what reaches dout.
  if (LATENCY > 1) begin : g_stages
    logic [WIDTH-1:0] dat_q [LATENCY-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= in_data;
      for (int s = 1; s < LATENCY - 1; s++) dat_q[s] <= dat_q[s-1];
    end
    assign tail_data = dat_q[LATENCY-2];
  end else begin : g_direct
    assign tail_data = in_data;
  end

  always_comb begin
    vld_d  = (vld_q << 1) | LATENCY'(in_valid);
    err_d  = (err_q << 1) | LATENCY'(in_err);
    dout_d = vld_d[LATENCY-1] ? tail_data : dout_q;
    if (corrupt) dout_d = 'x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      err_q  <= '0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      dout_q <= dout_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = dout_q;

endmodule

// File: rtl/sram_1rw_wmask_pipe.sv
// rtl/sram_1rw_wmask_pipe.sv - 1RW SRAM model with lane write mask and pipelined read
module sram_1rw_wmask_pipe
  import sram_wmask_pkg::*;
#(
  parameter int  WORD_SIZE    = 32,
  parameter int  WRITE_SIZE   = 8,
  parameter int  ADDR_WIDTH   = 8,
  parameter int  NUM_WORDS    = 256,
  parameter int  READ_LATENCY = 1,
  localparam int NUM_WMASKS   = num_wmasks(WORD_SIZE, WRITE_SIZE)
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_SIZE-1:0]  din0,
  output logic [WORD_SIZE-1:0]  dout0,
  output logic                  dout_valid0,
  output logic                  addr_err0
);

  if (WORD_SIZE % WRITE_SIZE != 0) begin : g_bad_lanes
    $error("WORD_SIZE must be a multiple of WRITE_SIZE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("READ_LATENCY out of range");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 2**ADDR_WIDTH) begin : g_bad_words
    $error("NUM_WORDS out of range");
  end

  localparam logic [ADDR_WIDTH:0] NUM_WORDS_L = NUM_WORDS[ADDR_WIDTH:0];

  logic [WORD_SIZE-1:0] mem_q [NUM_WORDS];
  acc_e                 acc;
  logic                 acc_x, in_range, rd_valid, rd_err, rd_pipe_err;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 wr_err_d, wr_err_q;

  // Unknown control falls to default, which poisons the array and the output.
  always_comb begin
    acc   = ACC_IDLE;
    acc_x = 1'b0;
    case ({csb0, web0})
      2'b00:        acc = ACC_WR;
      2'b01:        acc = ACC_RD;
      2'b10, 2'b11: acc = ACC_IDLE;
      default:      acc_x = 1'b1;
    endcase
    in_range = ({1'b0, addr0} < NUM_WORDS_L);
    rd_valid = (acc == ACC_RD);
    rd_err   = rd_valid && !in_range;
    rd_data  = in_range ? mem_q[addr0] : 'x;
    wr_err_d = (acc == ACC_WR) && !in_range;
  end

  // Array is never cleared by reset; reset only blocks new accesses.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (rstb0) begin
      if (acc_x) begin
        for (int w = 0; w < NUM_WORDS; w++) mem_q[w] <= 'x;
      end else if (acc == ACC_WR && in_range) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          case (wmask0[i])
            1'b1:    mem_q[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
            1'b0:    ;
            default: mem_q[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= 'x;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_err_d;
  end

  sram_rd_pipe #(
    .WIDTH   (WORD_SIZE),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk0),
    .rst_n     (rstb0),
    .in_valid  (rd_valid),
    .in_err    (rd_err),
    .in_data   (rd_data),
    .corrupt   (acc_x),
    .out_valid (dout_valid0),
    .out_err   (rd_pipe_err),
    .out_data  (dout0)
  );

  // Write errors report at commit, read errors at completion; they may coincide.
  assign addr_err0 = wr_err_q | rd_pipe_err;

endmodule
